// File: rtl/packer_pkg.sv
// Shared types and constants for the narrow-to-wide chunk packer.
package packer_pkg;

   localparam int IN_BYTES  = 32;
   localparam int OUT_BYTES = 160;
   localparam int CHUNKS    = OUT_BYTES / IN_BYTES;
   // Byte offset into the wide word; must hold OUT_BYTES itself (160).
   localparam int OFF_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/packer_if.sv
// Chunk-side and word-side handshake bundle for the packer.
// slave = packer view, master = driver/sink view.
interface packer_if #(
   parameter int IN_BYTES_P  = 32,
   parameter int OUT_BYTES_P = 160
);
   logic                     val;
   logic                     sop;
   logic                     eop;
   logic [7:0]               vbc;
   logic [IN_BYTES_P*8-1:0]  data;
   logic                     ready;

   logic                     o_val;
   logic                     o_sop;
   logic                     o_eop;
   logic [7:0]               o_vbc;
   logic [OUT_BYTES_P*8-1:0] o_data;
   logic                     o_ready;

   modport slave (
      input  val, sop, eop, vbc, data, o_ready,
      output ready, o_val, o_sop, o_eop, o_vbc, o_data
   );

   modport master (
      output val, sop, eop, vbc, data, o_ready,
      input  ready, o_val, o_sop, o_eop, o_vbc, o_data
   );
endinterface

// File: rtl/packer_buf.sv
// Wide word assembly buffer: writes the first wr_vbc bytes of a chunk at
// byte offset wr_off. clr empties the buffer first, so clear and write in the
// same cycle starts a fresh word at the written chunk.
module packer_buf
   import packer_pkg::*;
#(
   parameter int IN_BYTES_P  = 32,
   parameter int OUT_BYTES_P = 160
) (
   input  logic                     clk,
   input  logic                     reset_L,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [OFF_W-1:0]         wr_off,
   input  logic [7:0]               wr_vbc,
   input  logic [IN_BYTES_P*8-1:0]  wr_data,
   output logic [OUT_BYTES_P*8-1:0] data_q
);

   logic [OUT_BYTES_P*8-1:0] data_d;
   logic [IN_BYTES_P*8-1:0]  chunk_masked;
   logic [OUT_BYTES_P*8-1:0] chunk_ext;

   // Mask unused chunk bytes to zero, place them at the offset, merge in.
   always_comb begin
      chunk_masked = '0;
      for (int k = 0; k < IN_BYTES_P; k++) begin
         if (8'(k) < wr_vbc) chunk_masked[8*k +: 8] = wr_data[8*k +: 8];
      end
      chunk_ext = '0;
      chunk_ext[IN_BYTES_P*8-1:0] = chunk_masked;
      data_d = clr ? '0 : data_q;
      if (wr_en) data_d = data_d | (chunk_ext << {wr_off, 3'b000});
   end

   // Buffer register.
   always_ff @(posedge clk) begin
      if (!reset_L) data_q <= '0;
      else          data_q <= data_d;
   end

endmodule

// File: rtl/packer_fsm.sv
// Packs 32-byte chunks from one port into 160-byte words with a single-entry
// output buffer. Optional statistics counters: define PACKER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a sop chunk, buffer empty
// ACCUM | mid wide word, accepting continuation chunks
// HOLD  | word presented on o_val, waiting for o_ready
module packer_fsm
   import packer_pkg::*;
#(
   parameter int IN_BYTES_P  = 32,
   parameter int OUT_BYTES_P = 160,
   parameter int CNT_SIZE_P  = 8
) (
   input  logic                  clk,
   input  logic                  reset_L,
   packer_if.slave               bus,
   output logic                  error,
   output logic                  idle,
   output logic [CNT_SIZE_P-1:0] pkt_cnt,
   output logic [CNT_SIZE_P-1:0] err_cnt
);

   localparam logic [7:0] IN_B8  = 8'(IN_BYTES_P);
   localparam logic [7:0] OUT_B8 = 8'(OUT_BYTES_P);

   state_e           state_q, state_d;
   logic [OFF_W-1:0] offset_q, offset_d;
   logic             first_q, first_d;
   logic             eop_q, eop_d;
   logic             error_q, error_d;

   logic             hold;
   logic             accept;
   logic             vbc_bad;
   logic [OFF_W-1:0] append_off;
   logic             buf_clr;
   logic             buf_wr;
   logic [OFF_W-1:0] buf_off;

   assign hold       = (state_q == HOLD);
   assign accept     = bus.val && !hold;
   assign append_off = offset_q + bus.vbc;
   // Only the closing chunk of a packet may be short.
   assign vbc_bad    = (bus.vbc == 8'd0) || (bus.vbc > IN_B8) ||
                       (!bus.eop && (bus.vbc != IN_B8));

   // Next-state, buffer control and error detection.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      first_d  = first_q;
      eop_d    = eop_q;
      error_d  = 1'b0;
      buf_clr  = 1'b0;
      buf_wr   = 1'b0;
      buf_off  = offset_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (vbc_bad || !bus.sop) begin
                  error_d = 1'b1;
               end else begin
                  buf_wr   = 1'b1;
                  buf_off  = '0;
                  offset_d = bus.vbc;
                  first_d  = 1'b1;
                  eop_d    = bus.eop;
                  state_d  = (bus.eop || bus.vbc >= OUT_B8) ? HOLD : ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               if (vbc_bad) begin
                  error_d = 1'b1;
               end else if (bus.sop) begin
                  // Unterminated packet: drop the partial word, restart here.
                  error_d  = 1'b1;
                  buf_clr  = 1'b1;
                  buf_wr   = 1'b1;
                  buf_off  = '0;
                  offset_d = bus.vbc;
                  first_d  = 1'b1;
                  eop_d    = bus.eop;
                  state_d  = bus.eop ? HOLD : ACCUM;
               end else begin
                  buf_wr   = 1'b1;
                  offset_d = append_off;
                  eop_d    = bus.eop;
                  state_d  = (bus.eop || append_off == OUT_B8) ? HOLD : ACCUM;
               end
            end
         end
         HOLD: begin
            if (bus.o_ready) begin
               buf_clr  = 1'b1;
               offset_d = '0;
               eop_d    = 1'b0;
               first_d  = eop_q;
               state_d  = eop_q ? IDLE : ACCUM;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q  <= IDLE;
         offset_q <= '0;
         first_q  <= 1'b1;
         eop_q    <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         first_q  <= first_d;
         eop_q    <= eop_d;
         error_q  <= error_d;
      end
   end

   packer_buf #(
      .IN_BYTES_P  (IN_BYTES_P),
      .OUT_BYTES_P (OUT_BYTES_P)
   ) u_buf (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .wr_off  (buf_off),
      .wr_vbc  (bus.vbc),
      .wr_data (bus.data),
      .data_q  (bus.o_data)
   );

   // Word fields are held in flops, so they stay stable throughout HOLD.
   assign bus.ready = !hold;
   assign bus.o_val = hold;
   assign bus.o_sop = hold && first_q;
   assign bus.o_eop = hold && eop_q;
   assign bus.o_vbc = hold ? offset_q : 8'd0;
   assign error     = error_q;
   assign idle      = (state_q == IDLE) && (offset_q == '0);

`ifdef PACKER_STATS_EN
   logic [CNT_SIZE_P-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_SIZE_P-1:0] err_cnt_q, err_cnt_d;

   // Saturating packet and error counters.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (hold && bus.o_ready && eop_q && (pkt_cnt_q != '1))
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      if (error_d && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule

// File: doc/packer_fsm.md
Name: packer_fsm

Overview:
- Transmit-side counterpart of the per-port unpacker: collects narrow 32-byte chunks (val/sop/eop/vbc/data) from one port and packs them into wide 160-byte words on the shared wide packet interface.
- Single-entry output buffer with ready/valid backpressure on both sides.
- One instance per port inside the egress slice, driven by the port's reassembly path.

Parameters:
- IN_BYTES_P, 32, bytes per input chunk.
- OUT_BYTES_P, 160, bytes per output word; must be a multiple of IN_BYTES_P, giving CHUNKS = OUT_BYTES_P/IN_BYTES_P = 5.
- CNT_SIZE_P, 8, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset_L  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- val  in  1  input chunk valid.
- sop  in  1  first chunk of packet.
- eop  in  1  last chunk of packet.
- vbc  in  8  valid bytes in chunk, legal range 1..IN_BYTES_P.
- data  in  IN_BYTES_P*8  chunk data; byte k is data[8k+7:8k].
- ready  out  1  chunk accepted when val&ready.
- o_val  out  1  wide word valid.
- o_sop  out  1  first wide word of packet.
- o_eop  out  1  last wide word of packet.
- o_vbc  out  8  valid bytes in wide word, 1..OUT_BYTES_P.
- o_data  out  OUT_BYTES_P*8  wide word data.
- o_ready  in  1  downstream accepts the word when o_val&o_ready.
- error  out  1  one-cycle pulse on a protocol violation.
- idle  out  1  high in IDLE with no buffered bytes.
- pkt_cnt  out  CNT_SIZE_P  packets emitted (see Optional Feature).
- err_cnt  out  CNT_SIZE_P  errors flagged (see Optional Feature).

Behaviour:
- States:
  - IDLE: waiting for sop.
  - ACCUM: mid wide word.
  - HOLD: o_val high, waiting for o_ready.
- Reset values: state=IDLE, offset=0, buffer=0, first_word flag=1; outputs o_val/o_sop/o_eop=0, o_vbc=0, o_data=0, error=0, idle=1, counters=0. Reset mid-packet or mid-HOLD discards everything.
- Ready: ready=1 in IDLE and ACCUM; ready=0 in HOLD.
- A chunk is accepted on val&ready. Its bytes are written to buffer bytes [offset, offset+vbc); offset increases by vbc. Unwritten buffer bytes read as 0.
- Word launch: when the accepted chunk has eop, or offset reaches OUT_BYTES_P, the next state is HOLD. o_val rises the cycle after that chunk is accepted (1-cycle latency).
  - o_vbc = final offset.
  - o_sop = first_word flag.
  - o_eop = eop of the closing chunk.
- In HOLD on o_val&o_ready:
  - buffer and offset are cleared; o_val drops the next cycle.
  - Next state is IDLE if o_eop was 1, else ACCUM with first_word=0.
  - A new chunk cannot be accepted before the cycle after the handshake (1 bubble).
- Packets longer than OUT_BYTES_P produce multiple words: only the first carries o_sop, only the last carries o_eop.
- Transitions:
  - IDLE→ACCUM on a sop chunk without eop that leaves offset<OUT_BYTES_P.
  - IDLE→HOLD on sop&eop (single-chunk packet).
  - ACCUM→HOLD on eop or a full word.
- Error cases (error pulses the cycle after acceptance):
  - Chunk without sop in IDLE: dropped; state unchanged.
  - sop in ACCUM: partial word discarded; the chunk starts a new packet with first_word=1.
  - vbc==0 or vbc>IN_BYTES_P: chunk dropped; state unchanged.
  - Non-eop chunk with vbc!=IN_BYTES_P: chunk dropped; state unchanged.
- o_data, o_vbc, o_sop and o_eop are stable while o_val=1 and o_ready=0.
- sop&eop on the same chunk is legal.
- vbc arithmetic is unsigned 8-bit; offset is 8 bits, maximum 160.

Optional Feature:
- Macro PACKER_STATS_EN.
- Defined:
  - pkt_cnt increments by 1 on each o_val&o_ready&o_eop.
  - err_cnt increments by 1 on each error pulse.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: pkt_cnt and err_cnt are tied to 0 and no counter flops exist.

Decomposition:
- Package packer_pkg holds:
  - the state enum typedef (IDLE, ACCUM, HOLD);
  - localparam CHUNKS;
  - the byte-offset width constant.
- Optional sub-module packer_buf: the byte-lane write-enable and buffer register, taking offset/vbc/data plus a clear input. Control stays in packer_fsm.

Test Plan:
- Single chunk (sop=eop=1, vbc=20, data bytes 0x01..0x14) → o_val the next cycle: o_sop=o_eop=1, o_vbc=20, bytes 0..19 = 0x01..0x14, bytes 20..159 = 0.
- 5 chunks of 32 bytes, last with eop, o_ready=1 → one word: o_vbc=160, o_sop=o_eop=1; ready low for exactly 1 cycle after the 5th chunk.
- 7 chunks (6×32 + eop vbc=8) → word 1: o_sop=1, o_eop=0, o_vbc=160; word 2: o_sop=0, o_eop=1, o_vbc=40.
- Hold o_ready=0 for 10 cycles in HOLD → ready=0 and outputs stable throughout; the word transfers on the first o_ready=1 cycle.
- Errors: non-sop chunk in IDLE; sop after 2 chunks; vbc=33 → each gives error=1 for one cycle; with PACKER_STATS_EN, err_cnt=3 and pkt_cnt unchanged.
- Assert reset_L=0 for 1 cycle in ACCUM with offset=64 → all outputs at reset values; the next sop packet packs from offset 0.
